// File: rtl/apb_wait_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_wait_slave
//   APB memory slave with a programmable number of wait states per transfer.
//   Stores DEPTH 32-bit words starting at byte address BASE_ADDR. It also
//   keeps saturating counts of successful reads and writes. This lets the
//   AHB-to-APB bridge be exercised against a slave with variable latency.
//
// Ports
//   Pclk        in   1   APB clock, the only clock
//   Presetn     in   1   synchronous active-low reset
//   Psel        in   1   slave select
//   Penable     in   1   access phase
//   Pwrite      in   1   1 = write, 0 = read
//   Paddr       in   32  byte address
//   Pdata       in   32  write data
//   wait_cfg    in   4   wait states for the next transfer (0..15)
//   Pready      out  1   transfer completes this cycle
//   rdata_temp  out  32  read data, valid while Pready=1 on a read
//   Pslverr     out  1   error response, valid only while Pready=1
//   wr_count    out  16  successful writes, saturating
//   rd_count    out  16  successful reads, saturating
// ---------------------------------------------------------------------------
module apb_wait_slave #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Pclk,
    input  logic        Presetn,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pdata,
    input  logic [3:0]  wait_cfg,
    output logic        Pready,
    output logic [31:0] rdata_temp,
    output logic        Pslverr,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int IDX_W = $clog2(DEPTH);

    // The window limits are 33 bits wide so that BASE_ADDR + 4*DEPTH
    // cannot wrap when the window ends at the top of the address space.
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       data_q;
    logic              write_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    logic              addr_err;
    logic [IDX_W-1:0]  addr_idx;
    logic              commit_wr;

    // Decode the incoming address. The low index bits do not depend on how
    // the subtraction wraps, so a 32-bit difference is enough for the index.
    assign addr_err = (Paddr[1:0] != 2'b00)
                   || ({1'b0, Paddr} <  ADDR_LO)
                   || ({1'b0, Paddr} >= ADDR_HI);
    assign addr_idx = IDX_W'((Paddr - BASE_ADDR) >> 2);

    // A write lands only on the completion edge of a transfer with no error.
    assign commit_wr = Presetn && (state == ACCESS) && Psel && Pready
                    && write_q && !err_q;

    // The storage array has no reset, so its contents survive Presetn.
    always_ff @(posedge Pclk) begin
        if (commit_wr) begin
            mem[idx_q] <= data_q;
        end
    end

    // Transfer FSM. Pready is raised on the edge that ends the last wait
    // state. The edge that follows, while Pready is high, is the completion
    // edge: it commits the transfer and returns to IDLE. A setup phase in
    // the next cycle is therefore accepted with no dead cycle in between.
    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            Pready     <= 1'b0;
            Pslverr    <= 1'b0;
            rdata_temp <= 32'd0;
            wr_count   <= 16'd0;
            rd_count   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Psel && !Penable) begin
                        idx_q   <= addr_idx;
                        data_q  <= Pdata;
                        write_q <= Pwrite;
                        err_q   <= addr_err;
                        cnt     <= wait_cfg;
                        state   <= ACCESS;
                        if (wait_cfg == 4'd0) begin
                            Pready  <= 1'b1;
                            Pslverr <= addr_err;
                            if (!Pwrite) begin
                                rdata_temp <= addr_err ? 32'd0 : mem[addr_idx];
                            end
                        end else begin
                            Pready  <= 1'b0;
                            Pslverr <= 1'b0;
                        end
                    end
                end

                ACCESS: begin
                    if (!Psel) begin
                        // The master abandoned the transfer: nothing is committed.
                        Pready  <= 1'b0;
                        Pslverr <= 1'b0;
                        state   <= IDLE;
                    end else if (Pready) begin
                        if (!err_q) begin
                            if (write_q && (wr_count != 16'hFFFF)) begin
                                wr_count <= wr_count + 16'd1;
                            end
                            if (!write_q && (rd_count != 16'hFFFF)) begin
                                rd_count <= rd_count + 16'd1;
                            end
                        end
                        Pready  <= 1'b0;
                        Pslverr <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        Pready  <= 1'b1;
                        Pslverr <= err_q;
                        if (!write_q) begin
                            rdata_temp <= err_q ? 32'd0 : mem[idx_q];
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_apb_wait_slave
//   Directed bench for apb_wait_slave with DEPTH=256 and BASE_ADDR=0. The
//   driver pushes the expected response of each transfer into a queue. A
//   monitor pops an entry whenever Pready is seen and compares it.
// ---------------------------------------------------------------------------
module tb_apb_wait_slave;

    logic        Pclk;
    logic        Presetn;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pdata;
    logic [3:0]  wait_cfg;
    logic        Pready;
    logic [31:0] rdata_temp;
    logic        Pslverr;
    logic [15:0] wr_count;
    logic [15:0] rd_count;

    typedef struct {
        logic        is_write;
        logic        err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    exp_t        exp_q[$];
    int          num_checks;
    int          num_errors;
    int          access_cycles;
    logic [15:0] model_wr;
    logic [15:0] model_rd;

    apb_wait_slave #(
        .DEPTH     (256),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .Pclk       (Pclk),
        .Presetn    (Presetn),
        .Psel       (Psel),
        .Penable    (Penable),
        .Pwrite     (Pwrite),
        .Paddr      (Paddr),
        .Pdata      (Pdata),
        .wait_cfg   (wait_cfg),
        .Pready     (Pready),
        .rdata_temp (rdata_temp),
        .Pslverr    (Pslverr),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        Pclk = 1'b0;
        forever #5 Pclk = ~Pclk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: count the access cycles of the current transfer. When Pready
    // is high, pop the expected response and compare it.
    always @(negedge Pclk) begin
        if (!Presetn || !(Psel && Penable)) begin
            access_cycles = 0;
        end else begin
            access_cycles++;
        end
        if (Presetn && Pready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_pready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("latency", 32'(access_cycles), 32'(e.waits + 1));
                check_output("pslverr", {31'd0, Pslverr}, {31'd0, e.err});
                if (!e.is_write) begin
                    check_output("rdata", rdata_temp, e.rdata);
                end
            end
        end else begin
            check_output("pslverr_without_pready", {31'd0, Pslverr}, 32'd0);
        end
    end

    // One APB transfer. Entry and exit are 1 ns after a rising edge. On exit,
    // Psel is already low, so a following call forms a back-to-back setup.
    task automatic apply_stimulus(input logic is_write, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] wcfg,
                                  input logic exp_err, input logic [31:0] exp_rdata);
        exp_t e;
        bit   done;
        e.is_write = is_write;
        e.err      = exp_err;
        e.rdata    = exp_rdata;
        e.waits    = int'(wcfg);
        exp_q.push_back(e);
        Psel     = 1'b1;
        Penable  = 1'b0;
        Pwrite   = is_write;
        Paddr    = addr;
        Pdata    = data;
        wait_cfg = wcfg;
        @(posedge Pclk); #1;
        Penable  = 1'b1;
        wait_cfg = ~wcfg;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Pclk);
            if (Pready) done = 1'b1;
            @(posedge Pclk); #1;
        end
        if (!done) begin
            check_output("pready_timeout", 32'd0, 32'd1);
        end
        Psel    = 1'b0;
        Penable = 1'b0;
        if (!exp_err) begin
            if (is_write) model_wr++;
            else          model_rd++;
        end
    endtask

    task automatic check_counts;
        check_output("wr_count", {16'd0, wr_count}, {16'd0, model_wr});
        check_output("rd_count", {16'd0, rd_count}, {16'd0, model_rd});
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Pclk); #1;
        end
    endtask

    initial begin
        num_checks    = 0;
        num_errors    = 0;
        access_cycles = 0;
        model_wr      = 16'd0;
        model_rd      = 16'd0;
        Presetn  = 1'b0;
        Psel     = 1'b0;
        Penable  = 1'b0;
        Pwrite   = 1'b0;
        Paddr    = 32'd0;
        Pdata    = 32'd0;
        wait_cfg = 4'd0;
        idle_cycles(3);
        check_output("reset_pready", {31'd0, Pready}, 32'd0);
        check_output("reset_rdata", rdata_temp, 32'd0);
        Presetn = 1'b1;
        idle_cycles(1);

        // Make the counts and rdata_temp nonzero before the mid-transfer reset.
        apply_stimulus(1'b1, 32'h0, 32'h0BAD_F00D, 4'd0, 1'b0, 32'd0);
        apply_stimulus(1'b0, 32'h0, 32'd0,         4'd0, 1'b0, 32'h0BAD_F00D);
        check_counts();

        // Reset held for two edges while a wait_cfg=5 write is in its access phase.
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8;
        Pdata = 32'h5555_5555; wait_cfg = 4'd5;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(posedge Pclk); #1;
        Presetn = 1'b0;
        idle_cycles(2);
        Psel = 1'b0; Penable = 1'b0;
        Presetn = 1'b1;
        model_wr = 16'd0;
        model_rd = 16'd0;
        check_output("rst_pready", {31'd0, Pready}, 32'd0);
        check_output("rst_pslverr", {31'd0, Pslverr}, 32'd0);
        check_output("rst_rdata", rdata_temp, 32'd0);
        check_counts();

        // Zero wait states: a write, then a read of the same word.
        apply_stimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'd0, 1'b0, 32'd0);
        apply_stimulus(1'b0, 32'h10, 32'd0,         4'd0, 1'b0, 32'hDEAD_BEEF);
        check_counts();

        // Three wait states. Pready must be low in the cycle after completion.
        apply_stimulus(1'b1, 32'h20, 32'hCAFE_0020, 4'd3, 1'b0, 32'd0);
        @(negedge Pclk);
        check_output("pready_after_done", {31'd0, Pready}, 32'd0);
        @(posedge Pclk); #1;
        check_counts();

        // Error transfers: out of range and misaligned. Neither may alter memory.
        apply_stimulus(1'b1, 32'h400, 32'h1111_1111, 4'd2, 1'b1, 32'd0);
        apply_stimulus(1'b1, 32'h12,  32'h2222_2222, 4'd1, 1'b1, 32'd0);
        apply_stimulus(1'b0, 32'h400, 32'd0,         4'd0, 1'b1, 32'd0);
        apply_stimulus(1'b0, 32'h10,  32'd0,         4'd0, 1'b0, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, 32'h0,   32'd0,         4'd1, 1'b0, 32'h0BAD_F00D);
        check_counts();

        // Back-to-back: the read setup follows the write completion directly.
        apply_stimulus(1'b1, 32'h4, 32'h1234_5678, 4'd0, 1'b0, 32'd0);
        apply_stimulus(1'b0, 32'h4, 32'd0,         4'd2, 1'b0, 32'h1234_5678);
        check_counts();

        // Abort: Psel drops in the second access cycle of a wait_cfg=5 write.
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10;
        Pdata = 32'hBAD0_BAD0; wait_cfg = 4'd5;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(posedge Pclk); #1;
        Psel = 1'b0; Penable = 1'b0;
        idle_cycles(6);
        check_output("abort_pready", {31'd0, Pready}, 32'd0);
        check_counts();
        apply_stimulus(1'b0, 32'h10, 32'd0, 4'd1, 1'b0, 32'hDEAD_BEEF);

        // The maximum wait count, reading the word written with three waits.
        apply_stimulus(1'b0, 32'h20, 32'd0, 4'd15, 1'b0, 32'hCAFE_0020);
        idle_cycles(2);
        check_counts();
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
